// File: rtl/midi_uart_tx.sv
// -----------------------------------------------------------------------------
// midi_uart_tx
//
// MIDI (8N1, 31250 baud at the default clock) serial transmitter with a small
// byte FIFO in front of it. Bytes are queued through a valid/ready handshake
// and sent back to back, with no idle gap between frames, as long as the FIFO
// has data.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per MIDI bit (2..1023), default 32
//   FIFO_DEPTH   : byte FIFO entries, power of 2 from 2 to 16, default 4
//
// Ports
//   clk        : in  - single clock, rising edge
//   rst_n      : in  - synchronous active-low reset
//   tx_data    : in  - byte offered for transmission
//   tx_valid   : in  - tx_data is valid
//   tx_ready   : out - FIFO can accept a byte this cycle
//   midi_out   : out - serial MIDI line, idle high, driven from a register
//   busy       : out - frame in progress or FIFO non-empty
//   fifo_count : out - bytes queued, not counting the byte in flight
// -----------------------------------------------------------------------------
module midi_uart_tx #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          midi_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // ---------------------------------------------------------------------
    // FIFO state
    // ---------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // ---------------------------------------------------------------------
    // Transmitter state
    // ---------------------------------------------------------------------
    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    data_q;
    logic          midi_out_q;

    logic          push;
    logic          pop;
    logic          baud_end;
    logic [2:0]    bit_idx_next;
    logic [7:0]    head;

    // Handshake, pop decision and FIFO next state. Everything here depends on
    // registered state only, except push which also needs tx_valid.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        tx_ready     = (count_q != DEPTH_C);
        push         = tx_valid && tx_ready;
        baud_end     = (baud_q == BAUD_LAST);
        bit_idx_next = bit_idx_q + 3'd1;
        head         = mem[rd_ptr_q];

        // The transmitter takes a byte either straight from IDLE or at the
        // last cycle of a stop bit, so consecutive frames abut.
        pop = (count_q != '0) &&
              ((state_q == IDLE) || ((state_q == STOP) && baud_end));

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    // Frame sequencer. The baud counter marks bit boundaries; midi_out is
    // updated only at those boundaries, so each bit lasts exactly
    // CLKS_PER_BIT cycles and a frame exactly 10 * CLKS_PER_BIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            midi_out_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        state_q    <= START;
                        data_q     <= head;
                        midi_out_q <= 1'b0;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_q     <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= DATA;
                        midi_out_q <= data_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        // Wraps 7 -> 0, leaving the index clean for the next frame.
                        bit_idx_q <= bit_idx_next;
                        if (bit_idx_q == 3'd7) begin
                            state_q    <= STOP;
                            midi_out_q <= 1'b1;
                        end else begin
                            midi_out_q <= data_q[bit_idx_next];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            state_q    <= START;
                            data_q     <= head;
                            midi_out_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    baud_q     <= '0;
                    midi_out_q <= 1'b1;
                end
            endcase
        end
    end

    assign midi_out   = midi_out_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule
